// File: rtl/fp_pkg.sv
// ---------------------------------------------------------------------------
// fp_pkg
// Shared constants and types for the FP add/sub datapath.
//   FRAC_W       : fraction width (hidden + 23 fraction + guard/round/sticky)
//   EXP_W        : exponent width
//   SHIFT_RIGHT  : alignment shift, shifted-out bits fold into sticky
//   SHIFT_LEFT   : normalisation shift, zeros enter at the bottom
//   MAX_RSHIFT   : right shifts beyond this leave the result unchanged
//   MAX_LSHIFT   : left shifts beyond this leave the result all zeros
//   align_state_e: state encoding of fp_align_shifter
// ---------------------------------------------------------------------------
package fp_pkg;

    localparam int FRAC_W = 27;
    localparam int EXP_W  = 8;

    localparam logic SHIFT_RIGHT = 1'b0;
    localparam logic SHIFT_LEFT  = 1'b1;

    localparam int MAX_RSHIFT = 26;
    localparam int MAX_LSHIFT = 27;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } align_state_e;

endpackage

// File: rtl/fp_align_shifter_if.sv
// ---------------------------------------------------------------------------
// fp_align_shifter_if
// Request/result bundle between the FP adder control unit (master) and the
// alignment shifter (slave).
//   start       : request, honoured only while the shifter is idle
//   dir         : 0 = right shift with sticky, 1 = left shift
//   shift_qtt   : requested shift amount
//   frac_in     : fraction to shift
//   frac_out    : working/result fraction
//   busy        : shifter is shifting or signalling done
//   done        : one-cycle pulse, frac_out is final
//   shifts_done : shifts actually performed after clamping
// ---------------------------------------------------------------------------
interface fp_align_shifter_if #(
    parameter int FRAC_W = fp_pkg::FRAC_W,
    parameter int CNT_W  = 8
);
    logic              start;
    logic              dir;
    logic [CNT_W-1:0]  shift_qtt;
    logic [FRAC_W-1:0] frac_in;
    logic [FRAC_W-1:0] frac_out;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  shifts_done;

    modport master (
        output start, dir, shift_qtt, frac_in,
        input  frac_out, busy, done, shifts_done
    );

    modport slave (
        input  start, dir, shift_qtt, frac_in,
        output frac_out, busy, done, shifts_done
    );
endinterface

// File: rtl/fp_shift_step.sv
// ---------------------------------------------------------------------------
// fp_shift_step
// Combinational one-bit shift of a fraction.
//   dir_i  : 0 = right (bit shifted out is ORed into the sticky bit 0),
//            1 = left (zero enters at bit 0)
//   frac_i : fraction before the step
//   frac_o : fraction after the step
// ---------------------------------------------------------------------------
module fp_shift_step
    import fp_pkg::*;
#(
    parameter int W = fp_pkg::FRAC_W
) (
    input  logic         dir_i,
    input  logic [W-1:0] frac_i,
    output logic [W-1:0] frac_o
);

    // Select the shifted vector; the old sticky and the bit leaving bit 1
    // merge so the sticky never clears on a right shift.
    always_comb begin
        if (dir_i == SHIFT_LEFT) begin
            frac_o = {frac_i[W-2:0], 1'b0};
        end else begin
            frac_o = {1'b0, frac_i[W-1:2], frac_i[1] | frac_i[0]};
        end
    end

endmodule

// File: rtl/fp_align_shifter.sv
// ---------------------------------------------------------------------------
// fp_align_shifter
// Multi-cycle fraction shifter: one shift per clock, then a done pulse.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of fp_align_shifter_if (request in, result out)
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module fp_align_shifter #(
    parameter int FRAC_W = fp_pkg::FRAC_W,
    parameter int CNT_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    fp_align_shifter_if.slave  bus
);
    import fp_pkg::*;

    align_state_e      state_q, state_d;
    logic [FRAC_W-1:0] frac_q, frac_d, step_s;
    logic              dir_q, dir_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  shifts_q, shifts_d;
    logic [CNT_W-1:0]  clamp_s;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Shifts past the clamp cannot change the result, so never perform them.
    function automatic logic [CNT_W-1:0] clamp_count(
        input logic             d,
        input logic [CNT_W-1:0] q
    );
        logic [CNT_W-1:0] lim;
        if (d == SHIFT_LEFT) begin
            lim = CNT_W'(MAX_LSHIFT);
        end else begin
            lim = CNT_W'(MAX_RSHIFT);
        end
        return (q > lim) ? lim : q;
    endfunction

    assign clamp_s = clamp_count(bus.dir, bus.shift_qtt);

    fp_shift_step #(.W(FRAC_W)) u_step (
        .dir_i  (dir_q),
        .frac_i (frac_q),
        .frac_o (step_s)
    );

    // Next-state, datapath and output-flag decode.
    always_comb begin
        state_d  = state_q;
        frac_d   = frac_q;
        dir_d    = dir_q;
        cnt_d    = cnt_q;
        shifts_d = shifts_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    frac_d   = bus.frac_in;
                    dir_d    = bus.dir;
                    cnt_d    = clamp_s;
                    shifts_d = '0;
                    state_d  = (clamp_s == '0) ? ST_DONE : ST_SHIFT;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                frac_d   = step_s;
                cnt_d    = cnt_q - CNT_W'(1'b1);
                shifts_d = shifts_q + CNT_W'(1'b1);
                // <= also catches an (unreachable) zero count so the FSM cannot stick.
                if (cnt_q <= CNT_W'(1'b1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Flags are decoded from the next state so they can be registered.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            frac_q   <= '0;
            dir_q    <= SHIFT_RIGHT;
            cnt_q    <= '0;
            shifts_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            frac_q   <= frac_d;
            dir_q    <= dir_d;
            cnt_q    <= cnt_d;
            shifts_q <= shifts_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.frac_out    = frac_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.shifts_done = shifts_q;

endmodule

// File: tb/tb_fp_align_shifter.sv
// ---------------------------------------------------------------------------
// tb_fp_align_shifter
// Table of shift requests with expected results, a scoreboard queue filled
// at request time and drained on done, plus reset and busy-start sequences.
// ---------------------------------------------------------------------------
module tb_fp_align_shifter;

    typedef struct {
        logic        dir;
        logic [7:0]  qtt;
        logic [26:0] frac;
        logic [26:0] exp_frac;
        int          exp_shifts;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t tbl[16];
    vec_t sb[$];

    fp_align_shifter_if bus ();

    fp_align_shifter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_n(input logic d, input logic [7:0] q);
        if (d) return (q > 8'd27) ? 27 : int'(q);
        return (q > 8'd26) ? 26 : int'(q);
    endfunction

    // Closed form: right = logical shift with bit 0 = OR of frac[n:0].
    function automatic logic [26:0] ref_frac(input logic d, input logic [26:0] f, input int n);
        logic [26:0] r;
        logic [63:0] mask;
        if (d) begin
            r = f << n;
        end else begin
            mask = (64'd1 << (n + 1)) - 64'd1;
            r = f >> n;
            if (|({37'd0, f} & mask)) r[0] = 1'b1;
        end
        return r;
    endfunction

    task automatic run(input vec_t v, input bit disturb);
        int   k;
        vec_t e;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.dir       = v.dir;
        bus.shift_qtt = v.qtt;
        bus.frac_in   = v.frac;
        sb.push_back(v);
        @(negedge clk);
        bus.start     = 1'b0;
        bus.dir       = 1'($urandom);
        bus.shift_qtt = 8'($urandom);
        bus.frac_in   = 27'($urandom);
        k = 0;
        while (bus.done !== 1'b1 && k < 64) begin
            chk("busy_while_shifting", 32'(bus.busy), 32'd1);
            if (disturb && k == 2) begin
                bus.start     = 1'b1;
                bus.dir       = ~v.dir;
                bus.shift_qtt = 8'd1;
                bus.frac_in   = 27'h7FFFFFF;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        bus.start = 1'b0;
        e = sb.pop_front();
        chk("latency", 32'(k), 32'(e.exp_shifts));
        chk("busy_at_done", 32'(bus.busy), 32'd1);
        chk("frac_out", 32'(bus.frac_out), 32'(e.exp_frac));
        chk("shifts_done", 32'(bus.shifts_done), 32'(e.exp_shifts));
        @(negedge clk);
        chk("done_one_cycle", 32'(bus.done), 32'd0);
        chk("busy_after_done", 32'(bus.busy), 32'd0);
        chk("frac_hold", 32'(bus.frac_out), 32'(e.exp_frac));
        chk("shifts_hold", 32'(bus.shifts_done), 32'(e.exp_shifts));
    endtask

    initial begin
        vec_t v;
        tbl[0] = '{1'b0, 8'd3,   27'h4000000, 27'h0800000, 3};
        tbl[1] = '{1'b0, 8'd0,   27'h5A5A5A5, 27'h5A5A5A5, 0};
        tbl[2] = '{1'b0, 8'd200, 27'h4000001, 27'h0000001, 26};
        tbl[3] = '{1'b0, 8'd1,   27'h4000003, 27'h2000001, 1};
        tbl[4] = '{1'b1, 8'd2,   27'h0000005, 27'h0000014, 2};
        tbl[5] = '{1'b1, 8'd40,  27'h7FFFFFF, 27'h0000000, 27};
        tbl[6] = '{1'b0, 8'd26,  27'h0000000, 27'h0000000, 26};
        tbl[7] = '{1'b1, 8'd26,  27'h4000001, 27'h4000000, 26};
        tbl[8] = '{1'b0, 8'd27,  27'h7FFFFFF, 27'h0000001, 26};
        tbl[9] = '{1'b1, 8'd0,   27'h1234567, 27'h1234567, 0};
        for (int i = 10; i < 16; i++) begin
            tbl[i].dir        = 1'($urandom_range(0, 1));
            tbl[i].qtt        = 8'($urandom_range(0, 40));
            tbl[i].frac       = 27'($urandom);
            tbl[i].exp_shifts = ref_n(tbl[i].dir, tbl[i].qtt);
            tbl[i].exp_frac   = ref_frac(tbl[i].dir, tbl[i].frac, tbl[i].exp_shifts);
        end

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.dir       = 1'b0;
        bus.shift_qtt = 8'd0;
        bus.frac_in   = 27'd0;
        repeat (3) @(negedge clk);
        chk("rst_frac", 32'(bus.frac_out), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_shifts", 32'(bus.shifts_done), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) run(tbl[i], 1'b0);

        // A start while shifting must not disturb the running request.
        v = '{1'b0, 8'd10, 27'h4000000, 27'h0010000, 10};
        run(v, 1'b1);

        // Asynchronous reset in the middle of a shift drops the request.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.dir       = 1'b0;
        bus.shift_qtt = 8'd20;
        bus.frac_in   = 27'h7FFFFFF;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("busy_before_reset", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_frac", 32'(bus.frac_out), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_shifts", 32'(bus.shifts_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(tbl[4], 1'b0);
        run(tbl[0], 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fp_align_shifter.md
Name: fp_align_shifter

Overview:
- Multi-cycle fraction shifter for the FP add/sub datapath.
- Sits directly downstream of the FP adder control unit. It consumes that unit's shift amount and shift direction, and feeds the aligned or normalised fraction to the fraction ALU and the rounding logic.
- Right shifts (operand alignment) collapse shifted-out bits into a sticky bit in bit 0. Left shifts (normalisation) insert zeros.
- Performs one shift per clock and completes with a done pulse.

Parameters:
- FRAC_W, 27, fraction width: hidden bit + 23 fraction bits + guard, round and sticky.
- CNT_W, 8, shift amount width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  request; sampled only in IDLE
- dir  in  1  0 = right shift with sticky, 1 = left shift
- shift_qtt  in  CNT_W  requested shift amount, unsigned
- frac_in  in  FRAC_W  fraction to shift
- frac_out  out  FRAC_W  working/result register
- busy  out  1  high in SHIFT and DONE
- done  out  1  one-cycle pulse when frac_out is final
- shifts_done  out  CNT_W  number of shifts actually performed (after clamping)

Behaviour:
- Reset: clk and rst_n are the only clock and reset. Reset is asynchronous, active-low. Asserting rst_n=0 forces state=IDLE, frac_out=0, busy=0, done=0, shifts_done=0, cnt=0. This holds even mid-operation; the in-flight request is dropped.
- States: IDLE, SHIFT, DONE; 2-bit encoding.
- IDLE, start=1 at edge t:
  - frac_out<=frac_in; latch dir.
  - Right: cnt<=min(shift_qtt,26). Left: cnt<=min(shift_qtt,27).
  - shifts_done<=0.
  - Next state: DONE if the clamped cnt==0, else SHIFT.
- Clamp rationale:
  - After 26 right shifts the result is {26'b0, |frac_in}; further shifts change nothing.
  - After 27 left shifts the result is all zeros.
- SHIFT, each cycle:
  - Right: frac_out<={1'b0, frac_out[26:2], frac_out[1]|frac_out[0]}.
  - Left: frac_out<={frac_out[25:0], 1'b0}.
  - cnt<=cnt-1; shifts_done<=shifts_done+1.
  - When cnt==1, next state is DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Hold: frac_out and shifts_done hold their values after DONE until the next accepted start.
- Latency: start accepted at edge t → done high in the cycle after edge t+N, where N is the clamped count. N=0 gives done in the cycle after edge t.
- start while busy (SHIFT or DONE) is ignored. There is no queueing; the controller must wait for done.
- shift_qtt, dir and frac_in are don't-care except at the accepting edge.
- Invariant, right shift: bit 0 equals the OR of frac_in[k:0] after k shifts. Sticky is never cleared by a right shift.
- No X propagation: every state register has a reset value; default state → IDLE.

Decomposition:
- Shared package fp_pkg:
  - FRAC_W=27 and EXP_W=8.
  - Shift-direction constants SHIFT_RIGHT=0 and SHIFT_LEFT=1.
  - Clamp constants MAX_RSHIFT=26 and MAX_LSHIFT=27.
  - State encoding for this block.
- One natural sub-module, fp_shift_step: a combinational single-bit shift of a FRAC_W vector by dir with sticky merge.
- The FSM, counter and registers stay in fp_align_shifter.

Test Plan:
- Right, frac_in=27'h4000000, shift_qtt=3, start at t → frac_out=27'h0800000, shifts_done=3, done pulse in the cycle after edge t+3, busy high from t+1 through the done cycle.
- Right, shift_qtt=0, frac_in=27'h5A5A5A5 → frac_out=27'h5A5A5A5, done in the cycle after edge t, shifts_done=0.
- Right sticky/clamp:
  - frac_in=27'h4000001, shift_qtt=200 → shifts_done=26, frac_out=27'h0000001, done after 26 shifts.
  - frac_in=27'h4000003, shift_qtt=1 → frac_out=27'h2000001.
- Left, frac_in=27'h0000005, shift_qtt=2 → frac_out=27'h0000014. Left shift_qtt=40 → frac_out=0, shifts_done=27.
- start pulsed again during SHIFT with a different frac_in → ignored, first result unaffected. Then rst_n=0 mid-SHIFT → frac_out=0, busy=0, done=0 immediately (asynchronous), and a fresh start after release works normally.
